// File: rtl/multi_timer_pkg.sv
// Shared types for the multi-channel compare timer: per-channel FSM state encoding.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_t;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, compare counter, sticky status and done flag.
// Optional PWM output is present only when MULTI_TIMER_PWM_EN is defined.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] compare,
  input  logic             irq_clr,
`ifdef MULTI_TIMER_PWM_EN
  input  logic [WIDTH-1:0] duty,
  output logic             pwm,
`endif
  output logic [WIDTH-1:0] count,
  output logic             status,
  output logic             done
);

  ch_state_t        r_state;
  ch_state_t        w_next;
  logic [WIDTH-1:0] r_count;
  logic             r_status;
  logic [WIDTH:0]   w_inc;
  logic             w_hit;
  logic             w_match;

  // One extra bit keeps count+1 from wrapping when count is all-ones.
  assign w_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
  assign w_hit = (w_inc >= {1'b0, compare});

  always_comb begin
    w_next  = r_state;
    w_match = 1'b0;
    case (r_state)
      IDLE: if (en) w_next = RUN;
      RUN: begin
        if (!en) begin
          w_next = IDLE;
        end else if (tick && w_hit) begin
          w_match = 1'b1;
          if (oneshot) w_next = DONE;
        end
      end
      DONE:    if (!en) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A one-shot match leaves the counter untouched so the final value stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_status <= 1'b0;
    end else begin
      if (r_state == IDLE || w_next == IDLE) begin
        r_count <= '0;
      end else if (w_match && !oneshot) begin
        r_count <= '0;
      end else if (r_state == RUN && tick && !w_match) begin
        r_count <= w_inc[WIDTH-1:0];
      end
      if (w_match)      r_status <= 1'b1;
      else if (irq_clr) r_status <= 1'b0;
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  logic r_pwm;

  always_ff @(posedge clk) begin
    if (rst) r_pwm <= 1'b0;
    else     r_pwm <= (r_state == RUN) && (r_count < duty);
  end

  assign pwm = r_pwm;
`endif

  assign count  = r_count;
  assign status = r_status;
  assign done   = (r_state == DONE);

endmodule

// File: rtl/multi_timer.sv
// Multi-channel compare timer: shared prescaler, CHANNELS independent channels, OR'd irq.
// Define MULTI_TIMER_PWM_EN to add duty_val/pwm ports.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS*WIDTH-1:0] compare_val,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS-1:0]       irq_clr,
`ifdef MULTI_TIMER_PWM_EN
  input  logic [CHANNELS*WIDTH-1:0] duty_val,
  output logic [CHANNELS-1:0]       pwm,
`endif
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       irq_status,
  output logic [CHANNELS-1:0]       done,
  output logic                      irq
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  w_tick;
  logic [CHANNELS-1:0]   w_status;

  assign w_tick = (r_pcnt == prescale);

  // Prescaler parks at zero whenever no channel is enabled.
  always_ff @(posedge clk) begin
    if (rst || en == '0)       r_pcnt <= '0;
    else if (r_pcnt >= prescale) r_pcnt <= '0;
    else                       r_pcnt <= r_pcnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (w_tick),
      .en      (en[i]),
      .oneshot (oneshot[i]),
      .compare (compare_val[i*WIDTH +: WIDTH]),
      .irq_clr (irq_clr[i]),
`ifdef MULTI_TIMER_PWM_EN
      .duty    (duty_val[i*WIDTH +: WIDTH]),
      .pwm     (pwm[i]),
`endif
      .count   (count[i*WIDTH +: WIDTH]),
      .status  (w_status[i]),
      .done    (done[i])
    );
  end

  assign irq_status = w_status;
  assign irq        = |w_status;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (64-bit, 4 channels) with a behavioural channel model.
module tb_multi_timer;

  localparam int W  = 64;
  localparam int C  = 4;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [C-1:0]     en;
  logic [C-1:0]     oneshot;
  logic [C*W-1:0]   compare_val;
  logic [PW-1:0]    prescale;
  logic [C-1:0]     irq_clr;
  logic [C*W-1:0]   count;
  logic [C-1:0]     irq_status;
  logic [C-1:0]     done;
  logic             irq;
`ifdef MULTI_TIMER_PWM_EN
  logic [C*W-1:0]   duty_val;
  logic [C-1:0]     pwm;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: running/finished flags, count value, sticky flag per channel.
  bit             m_run [C];
  bit             m_fin [C];
  bit             m_st  [C];
  logic [W-1:0]   m_cnt [C];
  logic [PW-1:0]  m_pcnt;
`ifdef MULTI_TIMER_PWM_EN
  bit             m_pwm [C];
`endif

  multi_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .oneshot     (oneshot),
    .compare_val (compare_val),
    .prescale    (prescale),
    .irq_clr     (irq_clr),
`ifdef MULTI_TIMER_PWM_EN
    .duty_val    (duty_val),
    .pwm         (pwm),
`endif
    .count       (count),
    .irq_status  (irq_status),
    .done        (done),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit            tick;
    bit            hit;
    logic [W:0]    nxt;
    logic [W-1:0]  cmp;
    if (rst) begin
      m_pcnt = '0;
      for (int i = 0; i < C; i++) begin
        m_run[i] = 0; m_fin[i] = 0; m_st[i] = 0; m_cnt[i] = '0;
`ifdef MULTI_TIMER_PWM_EN
        m_pwm[i] = 0;
`endif
      end
      return;
    end
    tick = (m_pcnt == prescale);
    for (int i = 0; i < C; i++) begin
`ifdef MULTI_TIMER_PWM_EN
      m_pwm[i] = m_run[i] && (m_cnt[i] < duty_val[i*W +: W]);
`endif
      hit = 0;
      cmp = compare_val[i*W +: W];
      if (!en[i]) begin
        m_run[i] = 0; m_fin[i] = 0; m_cnt[i] = '0;
      end else if (!m_run[i] && !m_fin[i]) begin
        m_run[i] = 1; m_cnt[i] = '0;
      end else if (m_run[i] && tick) begin
        nxt = {1'b0, m_cnt[i]} + 65'd1;
        if (nxt >= {1'b0, cmp}) begin
          hit = 1;
          if (oneshot[i]) begin m_run[i] = 0; m_fin[i] = 1; end
          else m_cnt[i] = '0;
        end else begin
          m_cnt[i] = nxt[W-1:0];
        end
      end
      if (hit) m_st[i] = 1;
      else if (irq_clr[i]) m_st[i] = 0;
    end
    if (en == '0)              m_pcnt = '0;
    else if (m_pcnt >= prescale) m_pcnt = '0;
    else                       m_pcnt = m_pcnt + 1'b1;
  endtask

  function automatic logic [C*W-1:0] exp_count();
    logic [C*W-1:0] v;
    for (int i = 0; i < C; i++) v[i*W +: W] = m_cnt[i];
    return v;
  endfunction

  function automatic logic [C-1:0] exp_status();
    logic [C-1:0] v;
    for (int i = 0; i < C; i++) v[i] = m_st[i];
    return v;
  endfunction

  function automatic logic [C-1:0] exp_done();
    logic [C-1:0] v;
    for (int i = 0; i < C; i++) v[i] = m_fin[i];
    return v;
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = '0; oneshot = '0; irq_clr = '0; prescale = '0; compare_val = '0;
`ifdef MULTI_TIMER_PWM_EN
    duty_val = '0;
`endif
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1; en = '1; compare_val = {C{64'd2}};
    step(); step();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%h want=0", count); end
    checks++; if (irq_status !== '0) begin errors++; $display("FAIL reset_status got=%b want=0", irq_status); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    rst = 0; en = '0;
    step();
  endtask

  task automatic test_periodic();
    do_reset();
    compare_val[0*W +: W] = 64'd10; en[0] = 1;
    step();
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++; if (count[W-1:0] !== 64'(k)) begin errors++; $display("FAIL periodic_count k=%0d got=%0d want=%0d", k, count[W-1:0], k); end
      checks++; if (irq_status[0] !== 1'b0) begin errors++; $display("FAIL periodic_early_status k=%0d got=%b want=0", k, irq_status[0]); end
    end
    step();
    checks++; if (count[W-1:0] !== 64'd0 || irq_status[0] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL periodic_match got cnt=%0d st=%b irq=%b want cnt=0 st=1 irq=1", count[W-1:0], irq_status[0], irq);
    end
    irq_clr[0] = 1; step(); irq_clr[0] = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      checks++; if (count !== exp_count() || irq_status !== exp_status()) begin
        errors++; $display("FAIL periodic_model k=%0d got cnt=%0d st=%b want cnt=%0d st=%b", k, count[W-1:0], irq_status, m_cnt[0], exp_status());
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    compare_val[1*W +: W] = 64'd20; oneshot[1] = 1; en[1] = 1;
    step();
    for (int k = 1; k <= 19; k++) step();
    checks++; if (count[1*W +: W] !== 64'd19 || done[1] !== 1'b0) begin
      errors++; $display("FAIL oneshot_pre got cnt=%0d done=%b want cnt=19 done=0", count[1*W +: W], done[1]);
    end
    step();
    checks++; if (count[1*W +: W] !== 64'd19 || done[1] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL oneshot_done got cnt=%0d done=%b irq=%b want 19 1 1", count[1*W +: W], done[1], irq);
    end
    step(); step(); step();
    checks++; if (count[1*W +: W] !== 64'd19 || done[1] !== 1'b1) begin
      errors++; $display("FAIL oneshot_hold got cnt=%0d done=%b want 19 1", count[1*W +: W], done[1]);
    end
    en[1] = 0; step();
    checks++; if (count[1*W +: W] !== 64'd0 || done[1] !== 1'b0 || irq_status[1] !== 1'b1) begin
      errors++; $display("FAIL oneshot_disable got cnt=%0d done=%b st=%b want 0 0 1", count[1*W +: W], done[1], irq_status[1]);
    end
    irq_clr[1] = 1; step(); irq_clr[1] = 0;
    checks++; if (irq_status[1] !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL oneshot_clear got st=%b irq=%b want 0 0", irq_status[1], irq);
    end
  endtask

  task automatic test_prescale();
    do_reset();
    prescale = 8'd3; compare_val[2*W +: W] = 64'd5; en[2] = 1;
    for (int k = 1; k <= 19; k++) begin
      step();
      checks++; if (count !== exp_count() || irq_status[2] !== 1'b0) begin
        errors++; $display("FAIL prescale_run k=%0d got cnt=%0d st=%b want cnt=%0d st=0", k, count[2*W +: W], irq_status[2], m_cnt[2]);
      end
    end
    step();
    checks++; if (irq_status[2] !== 1'b1 || count[2*W +: W] !== 64'd0) begin
      errors++; $display("FAIL prescale_match got st=%b cnt=%0d want 1 0", irq_status[2], count[2*W +: W]);
    end
    irq_clr[2] = 1; step(); irq_clr[2] = 0;
    for (int k = 0; k < 19; k++) step();
    checks++; if (irq_status[2] !== 1'b1 || irq_status !== exp_status()) begin
      errors++; $display("FAIL prescale_second got st=%b want=%b", irq_status, exp_status());
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    compare_val[0*W +: W] = 64'd4; en[0] = 1;
    step(); step(); step(); step();
    irq_clr[0] = 1; step(); irq_clr[0] = 0;
    checks++; if (irq_status[0] !== 1'b1 || count[W-1:0] !== 64'd0) begin
      errors++; $display("FAIL clr_vs_set got st=%b cnt=%0d want st=1 cnt=0", irq_status[0], count[W-1:0]);
    end
    step();
    irq_clr[0] = 1; step(); irq_clr[0] = 0;
    checks++; if (irq_status[0] !== 1'b0) begin
      errors++; $display("FAIL clr_plain got st=%b want 0", irq_status[0]);
    end
  endtask

  task automatic test_wide();
    do_reset();
    compare_val[3*W +: W] = '1; en[3] = 1;
    step();
    for (int k = 0; k < 10; k++) step();
    checks++; if (count[3*W +: W] !== 64'd10) begin
      errors++; $display("FAIL wide_count got=%0d want=10", count[3*W +: W]);
    end
    compare_val[3*W +: W] = 64'd3;
    step();
    checks++; if (count[3*W +: W] !== 64'd0 || irq_status[3] !== 1'b1) begin
      errors++; $display("FAIL wide_lower got cnt=%0d st=%b want 0 1", count[3*W +: W], irq_status[3]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    compare_val[0*W +: W] = 64'd7; compare_val[1*W +: W] = 64'd3;
    oneshot[1] = 1; en[1:0] = 2'b11;
    for (int k = 0; k < 6; k++) step();
    checks++; if (done[1] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got done=%b irq=%b want 1 1", done[1], irq);
    end
    rst = 1; step(); rst = 0;
    checks++; if (count !== '0 || irq_status !== '0 || done !== '0 || irq !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got cnt=%h st=%b done=%b irq=%b want all 0", count, irq_status, done, irq);
    end
  endtask

  task automatic test_random(input logic [PW-1:0] ps);
    do_reset();
    prescale = ps;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < C; i++) begin
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 7) == 0) oneshot[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) compare_val[i*W +: W] = 64'($urandom_range(0, 12));
        irq_clr[i] = ($urandom_range(0, 4) == 0);
      end
      step();
      checks++; if (count !== exp_count()) begin
        errors++; $display("FAIL rand_count ps=%0d k=%0d got=%h want=%h", ps, k, count, exp_count());
      end
      checks++; if (irq_status !== exp_status() || done !== exp_done() || irq !== |exp_status()) begin
        errors++; $display("FAIL rand_flags ps=%0d k=%0d got st=%b done=%b irq=%b want st=%b done=%b", ps, k, irq_status, done, irq, exp_status(), exp_done());
      end
    end
  endtask

`ifdef MULTI_TIMER_PWM_EN
  task automatic test_pwm();
    int highs;
    do_reset();
    compare_val[0*W +: W] = 64'd10; duty_val[0*W +: W] = 64'd4; en[0] = 1;
    for (int k = 0; k < 15; k++) step();
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (pwm[0]) highs++;
      checks++; if (pwm[0] !== m_pwm[0]) begin
        errors++; $display("FAIL pwm_model k=%0d got=%b want=%b", k, pwm[0], m_pwm[0]);
      end
    end
    checks++; if (highs != 4) begin
      errors++; $display("FAIL pwm_duty got=%0d want=4", highs);
    end
  endtask
`endif

  initial begin
    rst = 1; en = '0; oneshot = '0; irq_clr = '0; prescale = '0; compare_val = '0;
`ifdef MULTI_TIMER_PWM_EN
    duty_val = '0;
`endif
    test_reset();
    test_periodic();
    test_oneshot();
    test_prescale();
    test_clr_collision();
    test_wide();
    test_reset_mid();
    test_random(8'd0);
    test_random(8'd2);
`ifdef MULTI_TIMER_PWM_EN
    test_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Multi-channel, parametrised compare timer with a shared prescaler, per-channel one-shot/periodic mode and sticky, individually clearable interrupt status. It is the next-generation system timer. It sits beside the CPU interrupt controller and provides CHANNELS independent counters plus a single aggregated interrupt line.

## Interface
- `WIDTH`, 32: counter and compare width per channel (≥ 2).
- `CHANNELS`, 4: number of independent channels (1–16).
- `PRESCALE_W`, 8: prescaler reload width.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  CHANNELS  per-channel enable (level).
- `oneshot`  in  CHANNELS  1 = one-shot, 0 = periodic; sampled every tick.
- `compare_val`  in  CHANNELS*WIDTH  flat; channel i at [i*WIDTH +: WIDTH].
- `prescale`  in  PRESCALE_W  tick every prescale+1 clocks.
- `irq_clr`  in  CHANNELS  write-1 pulse clears the status bit.
- `count`  out  CHANNELS*WIDTH  flat per-channel counters.
- `irq_status`  out  CHANNELS  sticky match flags.
- `done`  out  CHANNELS  one-shot channel has finished.
- `irq`  out  1  OR of irq_status.

## Operation
- Prescaler: `pcnt` counts 0..prescale; tick=1 when pcnt==prescale, then pcnt returns to 0. prescale=0 gives a tick every clock. pcnt is held at 0 while en==0 (all bits).
- Per-channel FSM states:
  - IDLE → RUN when en=1.
  - RUN → DONE on a one-shot match.
  - RUN/DONE → IDLE when en=0.
  - DONE holds until en deasserts.
- IDLE: count forced to 0; done=0.
- RUN, on tick: match when (count+1) ≥ compare_val, evaluated in WIDTH+1 bits so there is no overflow at all-ones.
  - Match, periodic: count←0, status←1.
  - Match, one-shot: count holds its value, status←1, done←1 (DONE).
  - No match: count←count+1.
- RUN without tick: all channel state holds.
- compare_val=0 or 1: match on every tick (period 1 tick).
- compare_val lowered below count+1 mid-run: match on the next tick. No wrap-through.
- irq_status: set on match, cleared by irq_clr. Set wins when both happen in the same cycle. en=0 does not clear status.
- irq = |irq_status, registered-path combinational OR (no extra latency).

## Timing
- Reset values: count=0, irq_status=0, done=0, irq=0, pcnt=0, all FSMs IDLE.
- en rising at edge E: the channel is RUN from E. The first tick increments count at E+1 when prescale=0.
- Periodic with prescale=0, compare=N: count sequence 0,1,…,N-1,0. Status rises at the edge where count goes N-1→0, and is visible the same cycle count reads 0.
- Reset mid-operation returns all registers to reset values at that edge, regardless of en or tick.
- Channels are fully independent; simultaneous matches on several channels set all their bits in one cycle.

## Configuration
- `MULTI_TIMER_PWM_EN` defined:
  - Adds input `duty_val` (CHANNELS*WIDTH, flat) and output `pwm` (CHANNELS).
  - pwm[i] = RUN && (count[i] < duty_val[i]), registered, 1-cycle lag behind count.
  - pwm is 0 in IDLE/DONE and at reset.
- Not defined: these ports and that logic are absent; everything else is identical.

## Structure
- Package `multi_timer_pkg`: channel state enum (IDLE, RUN, DONE) and the 2-bit state typedef.
- Sub-module `multi_timer_channel`:
  - Contains one FSM, counter, status/done bit and the optional pwm.
  - Takes tick, en, oneshot, compare, irq_clr.
  - Generated CHANNELS times; prescaler and irq OR stay in the top module.

## Test plan
- prescale=0, ch0 periodic, compare=10, en[0]=1 → count 0..9 repeats; irq_status[0] first set after 10 clocks and every 10 clocks thereafter (once cleared).
- ch1 one-shot, compare=20 → after 20 clocks count[1]=19 held, done[1]=1, irq=1; drop en[1] → count 0, done 0, status stays 1 until irq_clr.
- prescale=3, ch2 periodic, compare=5 → count advances every 4 clocks; match every 20 clocks.
- irq_clr[0] on the same cycle as a ch0 match → irq_status[0] remains 1; irq_clr on a non-match cycle → 0 next cycle.
- WIDTH=64 instance, compare=2^64-1 then lowered to 3 while count=10 → match on the next tick, count→0, no overflow.
- rst asserted mid-run with a one-shot in DONE → all outputs 0 next cycle; with `MULTI_TIMER_PWM_EN` and duty=4, compare=10 → pwm high for 4 of every 10 clocks.
